xnor_cmp_pipe: RTL and testbench

XNOR_CMP_PIPE -- requirements
Module: xnor_cmp_pipe

---
 rtl/xnor_cmp_pipe.sv | 89 ++++++++
 tb/tb_xnor_cmp_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_cmp_pipe.sv
// Registered bitwise XNOR/XOR comparator with a single valid/ready output stage.
// Define XNOR_CMP_STATS_EN to add the saturating mismatch counter on err_cnt.
module xnor_cmp_pipe #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CW-1:0]    match_cnt,
  output logic             all_eq,
  output logic [15:0]      err_cnt,
  input  logic             stats_clr
);

  logic [WIDTH-1:0] w_xnor;
  logic [WIDTH-1:0] w_y;
  logic [CW-1:0]    w_cnt;
  logic             w_eq;
  logic             w_accept;

  logic             r_valid;
  logic [WIDTH-1:0] r_y;
  logic [CW-1:0]    r_cnt;
  logic             r_eq;

  assign w_xnor   = ~(a ^ b);
  assign w_y      = mode ? ~w_xnor : w_xnor;
  assign w_eq     = &w_xnor;
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt = w_cnt + CW'(w_xnor[i]);
    end
  end

  // A consume without a new accept only drops valid; the data registers keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_eq    <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_y     <= w_y;
      r_cnt   <= w_cnt;
      r_eq    <= w_eq;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign y         = r_y;
  assign match_cnt = r_cnt;
  assign all_eq    = r_eq;

`ifdef XNOR_CMP_STATS_EN
  logic [15:0] r_err_cnt;

  // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_eq && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused;

  assign w_unused = stats_clr;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_xnor_cmp_pipe.sv
// Self-checking bench for xnor_cmp_pipe: scoreboard monitor plus directed scenario tasks.
// Statistics checks follow XNOR_CMP_STATS_EN.
module tb_xnor_cmp_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] match_cnt;
  logic       all_eq;
  logic [15:0] err_cnt;
  logic       stats_clr;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] cnt;
    logic       eq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  xnor_cmp_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .match_cnt (match_cnt),
    .all_eq    (all_eq),
    .err_cnt   (err_cnt),
    .stats_clr (stats_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result built bit by bit from equality of operand positions.
  function automatic exp_t model(input logic [7:0] fa, input logic [7:0] fb, input logic fm);
    exp_t r;
    r.cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      r.y[i] = (fa[i] == fb[i]) ? !fm : fm;
      if (fa[i] == fb[i]) r.cnt = r.cnt + 4'd1;
    end
    r.eq = (fa == fb);
    return r;
  endfunction

  // Scoreboard monitor: compares the held result every cycle, pops on consume, pushes on accept.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          $display("[TB] FAIL sb_spurious: out_valid=1 with y=%0h but no result expected", y);
        end else begin
          mon_e = sb[0];
          if ({y, match_cnt, all_eq} !== mon_e) begin
            $display("[TB] FAIL sb_result: got y=%0h cnt=%0d eq=%0b, expected y=%0h cnt=%0d eq=%0b",
                     y, match_cnt, all_eq, mon_e.y, mon_e.cnt, mon_e.eq);
          end else begin
            passed++;
          end
          if (out_ready) void'(sb.pop_front());
        end
      end else if (sb.size() != 0) begin
        total++;
        $display("[TB] FAIL sb_missing: out_valid=%0b while %0d result(s) pending", out_valid, sb.size());
        sb.delete();
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, mode));
    end
  end

  task automatic applyIdle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stats_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
    a = 8'h00; b = 8'h00; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %0b expected 0", out_valid); else passed++;
    total++; if (y !== 8'h00) $display("[TB] FAIL rst_y: got %0h expected 0", y); else passed++;
    total++; if (match_cnt !== 4'd0) $display("[TB] FAIL rst_cnt: got %0d expected 0", match_cnt); else passed++;
    total++; if (all_eq !== 1'b0) $display("[TB] FAIL rst_eq: got %0b expected 0", all_eq); else passed++;
    total++; if (err_cnt !== 16'h0) $display("[TB] FAIL rst_err: got %0h expected 0", err_cnt); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %0b expected 1", in_ready); else passed++;
  endtask

  task automatic test_vectors();
    in_valid = 1'b1; out_ready = 1'b1; a = 8'hA5; b = 8'hA5; mode = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL vec1_valid: got %0b expected 1", out_valid); else passed++;
    total++; if (y !== 8'hFF) $display("[TB] FAIL vec1_y: got %0h expected ff", y); else passed++;
    total++; if (match_cnt !== 4'd8) $display("[TB] FAIL vec1_cnt: got %0d expected 8", match_cnt); else passed++;
    total++; if (all_eq !== 1'b1) $display("[TB] FAIL vec1_eq: got %0b expected 1", all_eq); else passed++;
    a = 8'hF0; b = 8'h0F; mode = 1'b1;
    @(posedge clk); #1;
    total++; if (y !== 8'hFF) $display("[TB] FAIL vec2_y: got %0h expected ff", y); else passed++;
    total++; if (match_cnt !== 4'd0) $display("[TB] FAIL vec2_cnt: got %0d expected 0", match_cnt); else passed++;
    total++; if (all_eq !== 1'b0) $display("[TB] FAIL vec2_eq: got %0b expected 0", all_eq); else passed++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL drain_valid: got %0b expected 0", out_valid); else passed++;
    total++; if (y !== 8'hFF) $display("[TB] FAIL drain_hold_y: got %0h expected ff", y); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h3C; b = 8'h35; mode = 1'b0;
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready%0d: got %0b expected 0", i, in_ready); else passed++;
      @(posedge clk); #1;
      total++; if (y !== 8'hF6 || match_cnt !== 4'd6) $display("[TB] FAIL bp_hold%0d: got y=%0h cnt=%0d expected y=f6 cnt=6", i, y, match_cnt); else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %0b expected 1", in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || y !== 8'h26) $display("[TB] FAIL bp_swap: got valid=%0b y=%0h expected valid=1 y=26", out_valid, y); else passed++;
    applyIdle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [4] = '{8'h01, 8'hFF, 8'h5A, 8'h80};
    logic [7:0] pb [4] = '{8'h01, 8'h00, 8'h5B, 8'h7F};
    logic       pm [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_t e;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = pa[i]; b = pb[i]; mode = pm[i];
      e = model(pa[i], pb[i], pm[i]);
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || y !== e.y) $display("[TB] FAIL b2b_%0d: got valid=%0b y=%0h expected valid=1 y=%0h", i, out_valid, y, e.y);
      else passed++;
    end
    applyIdle();
  endtask

  task automatic test_random();
    logic m_valid;
    logic acc;
    m_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a         = 8'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      mode      = 1'($urandom);
      #1;
      total++;
      if (in_ready !== (!m_valid || out_ready)) $display("[TB] FAIL rand_ready%0d: got %0b expected %0b", i, in_ready, !m_valid || out_ready);
      else passed++;
      acc = in_valid && (!m_valid || out_ready);
      @(posedge clk); #1;
      m_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
    end
    applyIdle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h55; b = 8'h55; mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; a = 8'h0F; b = 8'h0E;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %0b expected 0", out_valid); else passed++;
    total++; if ({y, match_cnt, all_eq} !== 13'h0) $display("[TB] FAIL mid_data: got y=%0h cnt=%0d eq=%0b expected all 0", y, match_cnt, all_eq); else passed++;
    total++; if (err_cnt !== 16'h0) $display("[TB] FAIL mid_err: got %0h expected 0", err_cnt); else passed++;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_ready: got %0b expected 1", in_ready); else passed++;
    applyIdle();
  endtask

  task automatic test_stats();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stats_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; a = 8'h00; b = 8'h01; mode = 1'b0;
`ifdef XNOR_CMP_STATS_EN
    @(posedge clk); #1;
    total++; if (err_cnt !== 16'd1) $display("[TB] FAIL st_first: got %0h expected 1", err_cnt); else passed++;
    b = 8'h00;
    @(posedge clk); #1;
    total++; if (err_cnt !== 16'd1) $display("[TB] FAIL st_equal: got %0h expected 1", err_cnt); else passed++;
    b = 8'h01;
    repeat (65533) @(posedge clk);
    #1;
    total++; if (err_cnt !== 16'hFFFE) $display("[TB] FAIL st_preload: got %0h expected fffe", err_cnt); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (err_cnt !== 16'hFFFF) $display("[TB] FAIL st_saturate: got %0h expected ffff", err_cnt); else passed++;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    total++; if (err_cnt !== 16'h0) $display("[TB] FAIL st_clear: got %0h expected 0", err_cnt); else passed++;
    stats_clr = 1'b0;
    @(posedge clk); #1;
    total++; if (err_cnt !== 16'd1) $display("[TB] FAIL st_after_clr: got %0h expected 1", err_cnt); else passed++;
`else
    repeat (3) @(posedge clk);
    #1;
    total++; if (err_cnt !== 16'h0) $display("[TB] FAIL st_tied: got %0h expected 0", err_cnt); else passed++;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(posedge clk); #1;
    total++; if (err_cnt !== 16'h0) $display("[TB] FAIL st_tied_clr: got %0h expected 0", err_cnt); else passed++;
`endif
    applyIdle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
    a = 8'h00; b = 8'h00; mode = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_stats();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
